uart_tx_arbiter: RTL and testbench

//  Shares the single UART transmitter of the top-level design between N byte producers (processor

---
 rtl/uart_tx_arbiter_pkg.sv | 21 ++
 rtl/uart_tx_arbiter_if.sv | 29 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 35 +++
 rtl/uart_tx_arbiter.sv | 99 +++++++++
 tb/tb_uart_tx_arbiter.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// rtl/uart_tx_arbiter_pkg.sv - shared constants for the UART TX arbiter
package uart_tx_arbiter_pkg;

  typedef logic [0:0] state_t;

  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_WAIT = 1'b1;

  localparam int DATA_W_DEF = 8;

  // Watchdog default: one 8N1 frame (10 bit times) at the slowest baud the UART TX supports.
  localparam int CLK_HZ      = 50_000_000;
  localparam int BAUD_MIN    = 2_500;
  localparam int FRAME_BITS  = 10;
  localparam int TIMEOUT_DEF = (CLK_HZ / BAUD_MIN) * FRAME_BITS;

  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 == n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and UART TX handshake bundle
interface uart_tx_arbiter_if
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic                    tx_start;
  logic [DATA_W-1:0]       tx_data;
  logic                    tx_done_tick;
  logic [N_REQ-1:0]        grant;
  logic                    busy;
  logic                    timeout_err;

  modport master (
    input  req_valid, req_data, tx_done_tick,
    output req_ready, tx_start, tx_data, grant, busy, timeout_err
  );

  modport slave (
    output req_valid, req_data, tx_done_tick,
    input  req_ready, tx_start, tx_data, grant, busy, timeout_err
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rtl/uart_tx_arbiter_rr_pick.sv - combinational round-robin winner search
module uart_tx_arbiter_rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int PW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [PW-1:0]    idx,
  output logic             any
);

  always_comb begin
    int j;
    logic [PW-1:0] jp;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    j      = 0;
    jp     = '0;
    // Scan ptr, ptr+1, ... wrapping; first asserted request wins.
    for (int k = 0; k < N_REQ; k++) begin
      j  = (int'(ptr) + k) % N_REQ;
      jp = PW'(j);
      if (!any && req[jp]) begin
        any        = 1'b1;
        onehot[jp] = 1'b1;
        idx        = jp;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one UART TX between byte producers
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  uart_tx_arbiter_if.master bus
);

  localparam int PW   = $clog2(N_REQ);
  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  state_t            state;
  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     owner;
  logic [WD_W-1:0]   wd_cnt;

  logic [N_REQ-1:0]  pick_onehot;
  logic [PW-1:0]     pick_idx;
  logic              pick_any;
  logic [DATA_W-1:0] req_bytes [N_REQ];

  logic [N_REQ-1:0]  req_ready_q;
  logic [N_REQ-1:0]  grant_q;
  logic              tx_start_q;
  logic              busy_q;
  logic              timeout_err_q;
  logic [DATA_W-1:0] tx_data_q;
  logic              leave;

  uart_tx_arbiter_rr_pick #(.N_REQ(N_REQ), .PW(PW)) u_pick (
    .req    (bus.req_valid),
    .ptr    (rr_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      req_bytes[i] = bus.req_data[i*DATA_W +: DATA_W];
    end
  end

  assign leave = (state == ST_WAIT) && (bus.tx_done_tick || (wd_cnt == WD_LAST));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= ST_IDLE;
      rr_ptr        <= '0;
      owner         <= '0;
      wd_cnt        <= '0;
      req_ready_q   <= '0;
      grant_q       <= '0;
      tx_start_q    <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      tx_data_q     <= '0;
    end else begin
      req_ready_q   <= '0;
      tx_start_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      if (state == ST_IDLE) begin
        if (pick_any) begin
          state       <= ST_WAIT;
          owner       <= pick_idx;
          tx_data_q   <= req_bytes[pick_idx];
          req_ready_q <= pick_onehot;
          grant_q     <= pick_onehot;
          tx_start_q  <= 1'b1;
          busy_q      <= 1'b1;
          wd_cnt      <= '0;
        end
      end else if (leave) begin
        // A done tick on the last watchdog cycle is a normal completion, not an abort.
        state         <= ST_IDLE;
        grant_q       <= '0;
        busy_q        <= 1'b0;
        rr_ptr        <= PW'(next_idx(int'(owner), N_REQ));
        timeout_err_q <= !bus.tx_done_tick;
      end else begin
        wd_cnt <= wd_cnt + 1'b1;
      end
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.grant       = grant_q;
  assign bus.tx_start    = tx_start_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.tx_data     = tx_data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - randomized bench with transaction-level model of uart_tx_arbiter
module tb_uart_tx_arbiter;

  localparam int N  = 2;
  localparam int DW = 8;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;

  uart_tx_arbiter_if #(.N_REQ(N), .DATA_W(DW)) bus ();

  uart_tx_arbiter #(.N_REQ(N), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  bit          m_busy = 1'b0;
  bit          m_rst = 1'b1;
  bit          m_start = 1'b0;
  bit          m_err = 1'b0;
  int          m_owner = 0;
  int          m_age = 0;
  int          m_ptr = 0;
  logic [7:0]  m_byte = '0;
  logic [N-1:0] m_ready = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transfer-level model: one open transfer (owner, age, byte) or none.
  initial begin
    forever begin
      @(posedge clk);
      if (!reset) begin
        m_busy = 1'b0; m_rst = 1'b1; m_ptr = 0; m_byte = '0;
        m_ready = '0; m_start = 1'b0; m_err = 1'b0; m_owner = 0; m_age = 0;
      end else begin
        m_rst = 1'b0; m_start = 1'b0; m_err = 1'b0; m_ready = '0;
        if (!m_busy) begin
          for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (!m_busy && bus.req_valid[j]) begin
              m_busy = 1'b1; m_owner = j; m_age = 0; m_start = 1'b1;
              m_byte = bus.req_data[j*DW +: DW];
              m_ready[j] = 1'b1;
            end
          end
        end else if (bus.tx_done_tick || m_age == TO - 1) begin
          m_err  = !bus.tx_done_tick;
          m_busy = 1'b0;
          m_ptr  = (m_owner + 1) % N;
        end else begin
          m_age++;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        logic [N-1:0] eg;
        eg = m_busy ? N'(1 << m_owner) : '0;
        check("m_req_ready", 32'(bus.req_ready), 32'(m_ready));
        check("m_tx_start", 32'(bus.tx_start), 32'(m_start));
        check("m_grant", 32'(bus.grant), 32'(eg));
        check("m_busy", 32'(bus.busy), 32'(m_busy));
        check("m_timeout_err", 32'(bus.timeout_err), 32'(m_err));
        if (m_busy || m_rst) check("m_tx_data", 32'(bus.tx_data), 32'(m_byte));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "bench time limit");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_done();
    bus.tx_done_tick = 1'b1;
    cyc();
    bus.tx_done_tick = 1'b0;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.tx_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  bit ok;
  int n;

  initial begin
    bus.req_valid    = 2'b11;
    bus.req_data     = {8'h22, 8'h11};
    bus.tx_done_tick = 1'b0;

    // Reset held with both requesters valid
    for (int i = 0; i < 3; i++) begin
      cyc();
      cmp_en = 1'b1;
      @(negedge clk);
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_grant", 32'(bus.grant), 0);
      check("rst_tx_start", 32'(bus.tx_start), 0);
    end
    reset = 1'b1;
    cyc();
    @(negedge clk);
    check("rel_tx_start", 32'(bus.tx_start), 1);
    check("rel_grant", 32'(bus.grant), 32'h1);
    check("rel_tx_data", 32'(bus.tx_data), 32'h11);
    bus.req_valid = 2'b00;
    repeat (2) cyc();
    pulse_done();
    @(negedge clk);
    check("rel_busy_after_done", 32'(bus.busy), 0);

    // Single requester 1
    bus.req_data[15:8] = 8'hA5;
    bus.req_valid = 2'b10;
    cyc();
    @(negedge clk);
    check("one_req_ready", 32'(bus.req_ready), 32'h2);
    check("one_tx_start", 32'(bus.tx_start), 1);
    check("one_tx_data", 32'(bus.tx_data), 32'hA5);
    bus.req_valid = 2'b00;
    for (int i = 0; i < 5; i++) begin
      cyc();
      @(negedge clk);
      check("one_tx_data_hold", 32'(bus.tx_data), 32'hA5);
      check("one_req_ready_low", 32'(bus.req_ready), 0);
    end
    pulse_done();
    @(negedge clk);
    check("one_busy_after_done", 32'(bus.busy), 0);

    // Round robin with both valid continuously
    bus.req_data  = {8'h22, 8'h11};
    bus.req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_start(ok);
      check("rr_start_seen", 32'(ok), 1);
      check("rr_tx_data", 32'(bus.tx_data), (i % 2) ? 32'h22 : 32'h11);
      check("rr_grant", 32'(bus.grant), (i % 2) ? 32'h2 : 32'h1);
      repeat (3) cyc();
      pulse_done();
    end
    bus.req_valid = 2'b00;
    repeat (2) cyc();

    // Watchdog abort
    bus.req_data[7:0] = 8'h33;
    bus.req_valid = 2'b01;
    wait_start(ok);
    check("to_start_seen", 32'(ok), 1);
    check("to_grant", 32'(bus.grant), 32'h1);
    bus.req_valid = 2'b10;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (bus.timeout_err === 1'b1) break;
    end
    check("to_cycles", 32'(n), 16);
    check("to_busy", 32'(bus.busy), 0);
    wait_start(ok);
    check("to_next_seen", 32'(ok), 1);
    check("to_next_grant", 32'(bus.grant), 32'h2);
    bus.req_valid = 2'b00;
    pulse_done();

    // Stray done in IDLE, then done on the last watchdog cycle
    repeat (2) cyc();
    pulse_done();
    @(negedge clk);
    check("stray_busy", 32'(bus.busy), 0);
    check("stray_tx_start", 32'(bus.tx_start), 0);
    bus.req_valid = 2'b11;
    wait_start(ok);
    check("edge_start_seen", 32'(ok), 1);
    check("edge_grant", 32'(bus.grant), 32'h1);
    bus.req_valid = 2'b10;
    repeat (15) cyc();
    pulse_done();
    @(negedge clk);
    check("edge_timeout_err", 32'(bus.timeout_err), 0);
    check("edge_busy", 32'(bus.busy), 0);
    cyc();
    @(negedge clk);
    check("edge_timeout_err_next", 32'(bus.timeout_err), 0);
    check("edge_next_grant", 32'(bus.grant), 32'h2);

    // Reset mid-WAIT
    bus.req_valid = 2'b11;
    reset = 1'b0;
    cyc();
    @(negedge clk);
    check("mid_rst_busy", 32'(bus.busy), 0);
    check("mid_rst_grant", 32'(bus.grant), 0);
    check("mid_rst_tx_data", 32'(bus.tx_data), 0);
    check("mid_rst_timeout_err", 32'(bus.timeout_err), 0);
    reset = 1'b1;
    wait_start(ok);
    check("mid_rst_start_seen", 32'(ok), 1);
    check("mid_rst_grant_after", 32'(bus.grant), 32'h1);
    check("mid_rst_tx_data_after", 32'(bus.tx_data), 32'h33);
    bus.req_valid = 2'b00;
    pulse_done();

    // Random traffic, checked cycle by cycle against the model
    for (int i = 0; i < 3000; i++) begin
      cyc();
      bus.req_valid    = N'($urandom_range(0, 3));
      bus.req_data     = 16'($urandom);
      bus.tx_done_tick = ($urandom_range(0, 5) == 0);
      reset            = ($urandom_range(0, 199) != 0);
    end
    cyc();
    reset = 1'b1;
    bus.tx_done_tick = 1'b0;
    repeat (2) cyc();
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
